flash_read_arbiter: RTL

FLASH_READ_ARBITER -- requirements
Module: flash_read_arbiter

---
 rtl/flash_read_arbiter_if.sv | 32 +++
 rtl/flash_read_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/flash_read_arbiter_if.sv
// Client request/burst bus and flash-reader handshake for flash_read_arbiter.
// slave: the arbiter side; master: the clients plus flash reader side.
interface flash_read_arbiter_if;
  logic        req0;
  logic        req1;
  logic [23:0] addr0;
  logic [23:0] addr1;
  logic [7:0]  len0;
  logic [7:0]  len1;
  logic        ack0;
  logic        ack1;
  logic        done0;
  logic        done1;
  logic        err;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_owner;
  logic        fl_read;
  logic [23:0] fl_addr;
  logic        fl_ready;
  logic [7:0]  fl_data;

  modport slave (
    input  req0, req1, addr0, addr1, len0, len1, fl_ready, fl_data,
    output ack0, ack1, done0, done1, err, rd_valid, rd_data, rd_owner, fl_read, fl_addr
  );

  modport master (
    output req0, req1, addr0, addr1, len0, len1, fl_ready, fl_data,
    input  ack0, ack1, done0, done1, err, rd_valid, rd_data, rd_owner, fl_read, fl_addr
  );
endinterface

// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter for two burst readers sharing one byte-wide flash reader.
// Ack one cycle after grant, byte out one cycle after fl_ready; a stalled byte aborts after TIMEOUT cycles.
module flash_read_arbiter #(
  parameter int TIMEOUT = 64
) (
  input logic               clk,
  input logic               rstn,
  flash_read_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

  // Counter starts at 0 in the first WAIT cycle, so the abort fires TIMEOUT cycles after fl_read.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 2);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_rr;
  logic        r_owner;
  logic        r_err;
  logic        r_ack0;
  logic        r_ack1;
  logic        r_rd_valid;
  logic [7:0]  r_rd_data;
  logic [7:0]  r_cnt;
  logic [23:0] r_cur_addr;
  logic [8:0]  r_remaining;

  logic        w_grant_vld;
  logic        w_grant_id;
  logic [7:0]  w_len;
  logic        w_timeout;

  always_comb begin
    w_grant_vld = bus.req0 | bus.req1;
    w_grant_id  = (bus.req0 & bus.req1) ? r_rr : bus.req1;
    w_len       = w_grant_id ? bus.len1 : bus.len0;
    w_timeout   = (r_state == WAIT) && !bus.fl_ready && (r_cnt == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_grant_vld) w_state_nxt = ISSUE;
      ISSUE:   w_state_nxt = WAIT;
      WAIT: begin
        if (bus.fl_ready)   w_state_nxt = (r_remaining == 9'd1) ? FINISH : ISSUE;
        else if (w_timeout) w_state_nxt = FINISH;
      end
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rr        <= 1'b0;
      r_owner     <= 1'b0;
      r_err       <= 1'b0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= 8'h00;
      r_cnt       <= 8'h00;
      r_cur_addr  <= 24'h000000;
      r_remaining <= 9'd0;
    end else begin
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_rd_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_err <= 1'b0;
          if (w_grant_vld) begin
            r_owner     <= w_grant_id;
            r_cur_addr  <= w_grant_id ? bus.addr1 : bus.addr0;
            r_remaining <= (w_len == 8'd0) ? 9'd256 : {1'b0, w_len};
            r_ack0      <= !w_grant_id;
            r_ack1      <= w_grant_id;
          end
        end
        ISSUE: r_cnt <= 8'h00;
        WAIT: begin
          if (bus.fl_ready) begin
            r_rd_valid  <= 1'b1;
            r_rd_data   <= bus.fl_data;
            r_remaining <= r_remaining - 9'd1;
            r_cur_addr  <= r_cur_addr + 24'd1;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        FINISH: r_rr <= !r_owner;
        default: ;
      endcase
    end
  end

  assign bus.ack0     = r_ack0;
  assign bus.ack1     = r_ack1;
  assign bus.done0    = (r_state == FINISH) && !r_owner;
  assign bus.done1    = (r_state == FINISH) && r_owner;
  assign bus.err      = (r_state == FINISH) && r_err;
  assign bus.rd_valid = r_rd_valid;
  assign bus.rd_data  = r_rd_data;
  assign bus.rd_owner = r_owner;
  assign bus.fl_read  = (r_state == ISSUE);
  assign bus.fl_addr  = r_cur_addr;

endmodule
